// File: rtl/cpu_core.sv
// cpu_core: single-cycle 16-bit WISC-S18 core with PC, register file, flags and
// both memories. Build macro CPU_R0_ZERO_EN hardwires R0 to 0x0000.
module cpu_core (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc,
  output logic        hlt
);
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC, OP_BR  = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF;

  // Contents are preloaded by the surrounding environment (instructions.img / data.img).
  logic [15:0] imem [0:32767];
  logic [15:0] dmem [0:32767];

  logic [15:0] rf_q [0:15];
  logic [15:0] pc_q;
  logic [2:0]  flags_q, flags_d;

  logic [15:0] instruction, pc_current, PC_out, pc_plus2, br_target;
  logic [15:0] Read_data_1, Read_data_2, ALU_out, Write_data, mem_rdata, mem_addr;
  logic [15:0] alu_res, addsub_b, addsub_s, sat_res, padd_res;
  logic [3:0]  opcode, rd_addr, rs_addr, rt_addr, read_reg_2, write_reg, imm4;
  logic [8:0]  red_hi, red_lo;
  logic [9:0]  red_sum;
  logic [4:0]  nib;
  logic [2:0]  F;
  logic        RegWrite, MemRead, MemWrite, memory_enable, ovf, cond_met, wr_allowed;

  assign pc_current  = pc_q;
  assign F           = flags_q;
  assign instruction = imem[pc_current[15:1]];
  assign opcode      = instruction[15:12];
  assign rd_addr     = instruction[11:8];
  assign rs_addr     = instruction[7:4];
  assign rt_addr     = instruction[3:0];
  assign imm4        = instruction[3:0];

  // SW stores rt and LLB/LHB merge into rd, both held in [11:8].
  assign read_reg_2 = (opcode == OP_SW || opcode == OP_LLB || opcode == OP_LHB) ? rd_addr : rt_addr;

`ifdef CPU_R0_ZERO_EN
  assign Read_data_1 = (rs_addr == 4'd0) ? 16'h0000 : rf_q[rs_addr];
  assign Read_data_2 = (read_reg_2 == 4'd0) ? 16'h0000 : rf_q[read_reg_2];
  assign wr_allowed  = (write_reg != 4'd0);
`else
  assign Read_data_1 = rf_q[rs_addr];
  assign Read_data_2 = rf_q[read_reg_2];
  assign wr_allowed  = 1'b1;
`endif

  // Saturating add/sub: overflow when operand signs agree and the result sign differs.
  assign addsub_b = (opcode == OP_SUB) ? ~Read_data_2 : Read_data_2;
  assign addsub_s = Read_data_1 + addsub_b + {15'd0, opcode == OP_SUB};
  assign ovf      = (Read_data_1[15] == addsub_b[15]) && (addsub_s[15] != Read_data_1[15]);
  assign sat_res  = ovf ? (Read_data_1[15] ? 16'h8000 : 16'h7FFF) : addsub_s;

  assign red_hi  = {Read_data_1[15], Read_data_1[15:8]} + {Read_data_2[15], Read_data_2[15:8]};
  assign red_lo  = {Read_data_1[7], Read_data_1[7:0]} + {Read_data_2[7], Read_data_2[7:0]};
  assign red_sum = {red_hi[8], red_hi} + {red_lo[8], red_lo};

  assign mem_addr  = {Read_data_1[15:1], 1'b0} + {{11{imm4[3]}}, imm4, 1'b0};
  assign pc_plus2  = pc_q + 16'd2;
  assign br_target = pc_plus2 + {{6{instruction[8]}}, instruction[8:0], 1'b0};

  always_comb begin
    nib      = 5'd0;
    padd_res = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      nib = {Read_data_1[4*i+3], Read_data_1[4*i +: 4]} + {Read_data_2[4*i+3], Read_data_2[4*i +: 4]};
      padd_res[4*i +: 4] = (nib[4] != nib[3]) ? (nib[4] ? 4'h8 : 4'h7) : nib[3:0];
    end
  end

  always_comb begin
    alu_res = 16'h0000;
    flags_d = flags_q;
    case (opcode)
      OP_ADD, OP_SUB: begin
        alu_res = sat_res;
        flags_d = {sat_res == 16'h0000, ovf, sat_res[15]};
      end
      OP_XOR: begin
        alu_res    = Read_data_1 ^ Read_data_2;
        flags_d[2] = (alu_res == 16'h0000);
      end
      OP_RED:    alu_res = {{6{red_sum[9]}}, red_sum};
      OP_SLL: begin
        alu_res    = Read_data_1 << imm4;
        flags_d[2] = (alu_res == 16'h0000);
      end
      OP_SRA: begin
        alu_res    = $signed(Read_data_1) >>> imm4;
        flags_d[2] = (alu_res == 16'h0000);
      end
      OP_ROR: begin
        alu_res    = (Read_data_1 >> imm4) | (Read_data_1 << (5'd16 - {1'b0, imm4}));
        flags_d[2] = (alu_res == 16'h0000);
      end
      OP_PADDSB: alu_res = padd_res;
      OP_LW, OP_SW: alu_res = mem_addr;
      OP_LLB:    alu_res = {Read_data_2[15:8], instruction[7:0]};
      OP_LHB:    alu_res = {instruction[7:0], Read_data_2[7:0]};
      OP_PCS:    alu_res = pc_plus2;
      default:   alu_res = 16'h0000;
    endcase
  end

  // F = {Z, V, N}.
  always_comb begin
    case (instruction[11:9])
      3'b000:  cond_met = !F[2];
      3'b001:  cond_met = F[2];
      3'b010:  cond_met = !F[2] && !F[0];
      3'b011:  cond_met = F[0];
      3'b100:  cond_met = F[2] || (!F[2] && !F[0]);
      3'b101:  cond_met = F[0] || F[2];
      3'b110:  cond_met = F[1];
      default: cond_met = 1'b1;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_B:    PC_out = cond_met ? br_target : pc_plus2;
      OP_BR:   PC_out = cond_met ? Read_data_1 : pc_plus2;
      OP_HLT:  PC_out = pc_q;
      default: PC_out = pc_plus2;
    endcase
  end

  assign ALU_out       = alu_res;
  assign MemRead       = (opcode == OP_LW);
  assign MemWrite      = (opcode == OP_SW);
  assign memory_enable = MemRead || MemWrite;
  assign mem_rdata     = dmem[ALU_out[15:1]];
  assign RegWrite      = (opcode <= OP_LW) || (opcode == OP_LLB) || (opcode == OP_LHB) || (opcode == OP_PCS);
  assign write_reg     = rd_addr;
  assign Write_data    = MemRead ? mem_rdata : ALU_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= 16'h0000;
      flags_q <= 3'b000;
      for (int i = 0; i < 16; i++) rf_q[i] <= 16'h0000;
    end else begin
      pc_q    <= PC_out;
      flags_q <= flags_d;
      if (RegWrite && wr_allowed) rf_q[write_reg] <= Write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && memory_enable && MemWrite) dmem[ALU_out[15:1]] <= Read_data_2;
  end

  assign pc  = rst_n ? pc_current : 16'h0000;
  assign hlt = rst_n && (opcode == OP_HLT);
endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: runs a directed program against an instruction-level
// model of the ISA, checking the core's outputs and trace nets every cycle.
module tb_cpu_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc;
  logic        hlt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_core dut (.clk(clk), .rst_n(rst_n), .pc(pc), .hlt(hlt));

  // Architectural model state.
  logic [15:0] m_rf [16];
  logic [15:0] m_pc;
  logic        m_z, m_v, m_n;
  logic [15:0] m_dm [int];
  logic [15:0] m_im [int];
  int          m_hlt_cnt = 0;
  logic [31:0] exp_q [$];

  // Expected per-cycle outputs.
  logic        e_we, e_mw, e_mr, e_hlt;
  logic [3:0]  e_wr;
  logic [15:0] e_wd, e_npc;

  logic [15:0] prog [0:40] = '{
    16'hA134, 16'hB112, 16'hA410, 16'h9141, 16'h8541, 16'hA100, 16'hB170, 16'hB220,
    16'h0312, 16'h2812, 16'h3935, 16'h4A54, 16'h6B54, 16'h7C53, 16'h5DA2, 16'h1611,
    16'hC202, 16'hAFEE, 16'hAFEE, 16'hC002, 16'hBE80, 16'h1EE2, 16'h5FE4, 16'hCC01,
    16'hAFEE, 16'hCE06, 16'hAFEE, 16'hAFEE, 16'hAFEE, 16'hAFEE, 16'hAFEE, 16'hAFEE,
    16'hE700, 16'hA750, 16'hD270, 16'hDE70, 16'hAFEE, 16'hAFEE, 16'hAFEE, 16'hAFEE,
    16'hF000};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rreg(input logic [3:0] idx);
`ifdef CPU_R0_ZERO_EN
    if (idx == 4'd0) return 16'h0000;
`endif
    return m_rf[idx];
  endfunction

  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic logic cond_ok(input logic [2:0] c);
    case (c)
      3'd0: return !m_z;
      3'd1: return m_z;
      3'd2: return !m_z && !m_n;
      3'd3: return m_n;
      3'd4: return m_z || (!m_z && !m_n);
      3'd5: return m_n || m_z;
      3'd6: return m_v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
    m_pc = 16'h0000;
    {m_z, m_v, m_n} = 3'b000;
    m_hlt_cnt = 0;
  endtask

  // Execute one instruction on the model and record what the core must show.
  task automatic model_step();
    logic [15:0] ins, a, b, r, addr;
    logic [3:0]  op, rd, rs, rt;
    int s, x, y;
    ins = m_im.exists(int'(m_pc[15:1])) ? m_im[int'(m_pc[15:1])] : 16'hF000;
    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    a = rreg(rs); b = rreg(rt); r = 16'h0000;
    e_we = 1'b1; e_mw = 1'b0; e_mr = 1'b0; e_hlt = 1'b0; e_wr = rd;
    e_npc = m_pc + 16'd2;
    case (op)
      4'h0, 4'h1: begin
        s = (op == 4'h0) ? sx(int'(a), 16) + sx(int'(b), 16) : sx(int'(a), 16) - sx(int'(b), 16);
        m_v = (s > 32767) || (s < -32768);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        r = s[15:0];
        m_z = (r == 16'h0000);
        m_n = (s < 0);
      end
      4'h2: begin r = a ^ b; m_z = (r == 16'h0000); end
      4'h3: begin
        s = sx(int'(a[15:8]), 8) + sx(int'(b[15:8]), 8) + sx(int'(a[7:0]), 8) + sx(int'(b[7:0]), 8);
        r = s[15:0];
      end
      4'h4: begin r = a << rt; m_z = (r == 16'h0000); end
      4'h5: begin s = sx(int'(a), 16) >>> rt; r = s[15:0]; m_z = (r == 16'h0000); end
      4'h6: begin r = (a >> rt) | (a << (16 - int'(rt))); m_z = (r == 16'h0000); end
      4'h7: begin
        for (int i = 0; i < 4; i++) begin
          x = sx(int'((a >> (4 * i)) & 16'hF), 4) + sx(int'((b >> (4 * i)) & 16'hF), 4);
          if (x > 7) x = 7;
          if (x < -8) x = -8;
          y = x & 15;
          r = r | 16'(y << (4 * i));
        end
      end
      4'h8: begin
        addr = (a & 16'hFFFE) + 16'(sx(int'(rt), 4) * 2);
        r = m_dm.exists(int'(addr[15:1])) ? m_dm[int'(addr[15:1])] : 16'h0000;
        e_mr = 1'b1;
      end
      4'h9: begin
        addr = (a & 16'hFFFE) + 16'(sx(int'(rt), 4) * 2);
        e_we = 1'b0; e_mw = 1'b1;
        exp_q.push_back({addr, rreg(rd)});
        m_dm[int'(addr[15:1])] = rreg(rd);
      end
      4'hA: r = {rreg(rd) & 16'hFF00} | {8'h00, ins[7:0]};
      4'hB: r = {rreg(rd) & 16'h00FF} | {ins[7:0], 8'h00};
      4'hC: begin
        e_we = 1'b0;
        if (cond_ok(ins[11:9])) e_npc = m_pc + 16'd2 + 16'(sx(int'(ins[8:0]), 9) * 2);
      end
      4'hD: begin e_we = 1'b0; if (cond_ok(ins[11:9])) e_npc = a; end
      4'hE: r = m_pc + 16'd2;
      default: begin e_we = 1'b0; e_hlt = 1'b1; e_npc = m_pc; end
    endcase
    e_wd = r;
`ifdef CPU_R0_ZERO_EN
    if (e_we && rd != 4'd0) m_rf[rd] = r;
`else
    if (e_we) m_rf[rd] = r;
`endif
    m_pc = e_npc;
    m_hlt_cnt = e_hlt ? m_hlt_cnt + 1 : 0;
  endtask

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    logic [31:0] st;
    if (!rst_n) begin
      check("pc_in_reset", pc, 16'h0000);
      check("hlt_in_reset", {15'd0, hlt}, 16'h0000);
      model_reset();
    end else begin
      check("pc", pc, m_pc);
      check("flags", {13'd0, dut.F}, {13'd0, m_z, m_v, m_n});
      model_step();
      check("hlt", {15'd0, hlt}, {15'd0, e_hlt});
      check("RegWrite", {15'd0, dut.RegWrite}, {15'd0, e_we});
      check("MemWrite", {15'd0, dut.MemWrite}, {15'd0, e_mw});
      check("MemRead", {15'd0, dut.MemRead}, {15'd0, e_mr});
      check("PC_out", dut.PC_out, e_npc);
      if (e_we) begin
        check("write_reg", {12'd0, dut.write_reg}, {12'd0, e_wr});
        check("Write_data", dut.Write_data, e_wd);
      end
      if (e_mw) begin
        st = exp_q.pop_front();
        check("store_addr", dut.ALU_out, st[31:16]);
        check("store_data", dut.Read_data_2, st[15:0]);
        check("memory_enable", {15'd0, dut.memory_enable}, 16'h0001);
      end
    end
  end

  task automatic run_to_halt(input string tag);
    int c;
    c = 0;
    while (m_hlt_cnt < 4 && c < 300) begin
      @(posedge clk);
      c++;
    end
    n_tests++;
    if (m_hlt_cnt < 4) begin
      n_fail++;
      $display("FAIL %s_timeout: halted cycles %0d required 4", tag, m_hlt_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) dut.imem[i] = 16'hF000;
    for (int i = 0; i <= 40; i++) begin
      dut.imem[i] = prog[i];
      m_im[i]     = prog[i];
    end
    model_reset();

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_to_halt("run1");

    // Reset while halted, then rerun the whole program.
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_to_halt("run2");

    // Hand-computed results pin the model.
    check("lit_r1", m_rf[1], 16'h7000);
    check("lit_r2", m_rf[2], 16'h2000);
    check("lit_r3_add_sat", m_rf[3], 16'h7FFF);
    check("lit_r4", m_rf[4], 16'h0010);
    check("lit_r5_lw", m_rf[5], 16'h1234);
    check("lit_r6_sub", m_rf[6], 16'h0000);
    check("lit_r7", m_rf[7], 16'h0050);
    check("lit_r8_xor", m_rf[8], 16'h5000);
    check("lit_r9_red", m_rf[9], 16'h00C4);
    check("lit_r10_sll", m_rf[10], 16'h2340);
    check("lit_r11_ror", m_rf[11], 16'h4123);
    check("lit_r12_paddsb", m_rf[12], 16'h7123);
    check("lit_r13_sra", m_rf[13], 16'h08D0);
    check("lit_r14_sub_sat", m_rf[14], 16'h8000);
    check("lit_r15_sra_neg", m_rf[15], 16'hF800);
    check("lit_pc_halt", m_pc, 16'h0050);
    check("lit_flags", {13'd0, m_z, m_v, m_n}, 16'h0003);

    check("dut_pc_halt", pc, 16'h0050);
    check("dut_dmem_0x12", dut.dmem[9], 16'h1234);
    for (int i = 0; i < 16; i++) check($sformatf("dut_rf_r%0d", i), dut.rf_q[i], m_rf[i]);
    check("store_queue_empty", 16'(exp_q.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_core.md
# cpu_core

Single-cycle 16-bit WISC-S18 processor, phase 1. Holds the PC, a 16×16 register file, the Z/V/N flag register, instruction memory and data memory. Each instruction is fetched, executed and committed in one clock. It is the top-level core under the phase-1 trace testbench, which probes the named internal nets listed below.

## Interface

- No parameters.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low; clock clk.
- `pc`  output  16  byte address of the instruction currently being executed.
- `hlt`  output  1  high while the current instruction is HLT and `rst_n`=1.
- Required internal nets, used for tracing:
  - `instruction[15:0]`: fetched word.
  - `RegWrite`, `write_reg[3:0]`, `Write_data[15:0]`: register-file write controls.
  - `MemRead`, `MemWrite`, `memory_enable`: data-memory controls.
  - `ALU_out[15:0]`: data address.
  - `Read_data_2[15:0]`: store data.
  - `F[2:0]`: flags {Z,V,N}.
  - `pc_current`: PC register value.
  - `PC_out`: next PC.

## Operation

- Memories:
  - 32768×16 instruction memory and 32768×16 data memory, both indexed by `addr[15:1]`.
  - Asynchronous read; data-memory write on the rising edge.
  - Initialised by `$readmemh` from `instructions.img` and `data.img`.
- Instruction fields: `[15:12]` opcode, `[11:8]` rd/rt, `[7:4]` rs, `[3:0]` rt/imm4.
- 0 ADD, 1 SUB:
  - rd = rs ± rt, saturated to 0x7FFF or 0x8000.
  - Z, V and N all updated; V=1 on overflow.
- 2 XOR: rd = rs ^ rt; Z updated.
- 3 RED:
  - Each source is split into signed bytes; result = (rs.hi + rt.hi) + (rs.lo + rt.lo).
  - The 10-bit sum is sign-extended to 16 bits; flags unchanged.
- 4 SLL, 5 SRA, 6 ROR: rd = rs shifted or rotated by imm4; Z updated.
- 7 PADDSB: four independent 4-bit signed saturating adds (range −8..7); flags unchanged.
- 8 LW: rt = Dmem[(rs & 0xFFFE) + (sext(imm4) << 1)]; `MemRead`=1.
- 9 SW: Dmem[same address] = rt; `MemWrite`=`memory_enable`=1; `Read_data_2` carries rt.
- A LLB: rd = (rd & 0xFF00) | imm8.
- B LHB: rd = (rd & 0x00FF) | (imm8 << 8).
- C B: if cond(ccc=`[11:9]`), PC = PC+2 + (sext(imm9) << 1); else PC+2.
- D BR: if cond, PC = rs; else PC+2.
- E PCS: rd = PC+2.
- F HLT: PC holds; `hlt`=1.
- Condition codes (ccc):
  - 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1.
  - 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
- Flags write only for the instructions listed; every other instruction leaves them unchanged.
- `RegWrite`=1 for opcodes 0–8, A, B, E.
- Register reads are asynchronous. A write in cycle N is visible to the read in cycle N+1.

## Timing

- Reset (`rst_n`=0 at a rising edge):
  - PC, all registers and flags go to 0; no memory write occurs.
  - `hlt`=0 and `pc`=0 while held in reset.
- Latency: one cycle per instruction; PC, register, flag and Dmem updates are visible after the next rising edge.
- HLT: the PC, registers and memory freeze for as long as HLT is fetched; `hlt` stays high.
- Same-cycle hazard: an instruction that reads and writes the same register (e.g. LLB/LHB on rd) reads the old value.
- Reset mid-program: overrides everything, including a pending SW and HLT.
- PC arithmetic wraps modulo 2^16.

## Configuration

- `CPU_R0_ZERO_EN` defined: R0 always reads 0x0000 and writes to it are discarded; `RegWrite` may still assert.
- `CPU_R0_ZERO_EN` undefined: R0 is an ordinary register.

## Test plan

- Reset then LLB R1,0x34; LHB R1,0x12 -> R1=0x1234 after 2 cycles; `pc`=0x0004.
- R1=0x7000, R2=0x2000, ADD R3,R1,R2 -> R3=0x7FFF, V=1, N=0, Z=0.
- SW R1,R4,1 with R4=0x0010, then LW R5,R4,1 -> Dmem addr 0x0012 = 0x1234, R5=0x1234, `MemRead`=1 on the LW.
- SUB R6,R1,R1 then B ccc=001 with imm9=+2 at PC 0x0020 -> next PC 0x0026; with ccc=000 -> 0x0022.
- PCS R7 at PC 0x0040, then BR 111,R7 -> R7=0x0042; PC=0x0042.
- HLT at 0x0050 -> `hlt`=1; `pc` stays 0x0050 for 3+ cycles; no `RegWrite`/`MemWrite`.
